// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NREQ byte producers. Requesters are
// served round-robin, one byte per grant. After each frame (transmitter done
// or watchdog expiry) the arbiter holds an inter-frame gap of IFG_CYC cycles
// before arbitrating again.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   req          per-requester request level
//   req_data     byte of requester i in bits [8i+7:8i]
//   ack          one-cycle pulse, one-hot: requester's byte was taken
//   tx_din       byte presented to the transmitter (held until next issue)
//   tx_first     one-cycle start pulse to the transmitter
//   tx_done      transmitter done level; only its rising edge is used
//   grant_id     index of the requester currently being served
//   busy         high whenever the arbiter is not idle
//   err_timeout  one-cycle pulse when the transmitter never reported done
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int IFG_CYC     = 16,
  parameter int TIMEOUT_CYC = 120000,
  parameter int TW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         ack,
  output logic [7:0]              tx_din,
  output logic                    tx_first,
  input  logic                    tx_done,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int IW = $clog2(NREQ);
  localparam int GW = $clog2(IFG_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [TW-1:0]   timer_q;
  logic [GW-1:0]   gap_q;
  logic            done_q;
  logic [NREQ-1:0] ack_q;
  logic [7:0]      tx_din_q;
  logic            tx_first_q;
  logic [IW-1:0]   grant_id_q;
  logic            busy_q;
  logic            err_q;

  logic            done_rise;
  logic            win_valid;
  logic [IW-1:0]   win_idx;
  logic [7:0]      win_byte;

  assign done_rise = tx_done & ~done_q;

  // Round-robin winner: scan offsets from the pointer downwards so that the
  // smallest offset (closest to rr_ptr, wrapping) is the last to be written.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_byte  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr_q) + k) % NREQ]) begin
        win_valid = 1'b1;
        win_idx   = IW'((int'(rr_ptr_q) + k) % NREQ);
        win_byte  = req_data[((int'(rr_ptr_q) + k) % NREQ) * 8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      timer_q    <= '0;
      gap_q      <= '0;
      done_q     <= 1'b0;
      ack_q      <= '0;
      tx_din_q   <= '0;
      tx_first_q <= 1'b0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q     <= tx_done;
      // Pulse outputs default low; only the transitions below raise them.
      ack_q      <= '0;
      tx_first_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            state_q          <= S_ISSUE;
            tx_din_q         <= win_byte;
            tx_first_q       <= 1'b1;
            ack_q[win_idx]   <= 1'b1;
            grant_id_q       <= win_idx;
            rr_ptr_q         <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            busy_q           <= 1'b1;
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A done edge wins over a simultaneous expiry.
          if (done_rise) begin
            state_q <= S_GAP;
            timer_q <= '0;
            gap_q   <= '0;
          end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_GAP;
            timer_q <= '0;
            gap_q   <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_q == GW'(IFG_CYC - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign tx_din      = tx_din_q;
  assign tx_first    = tx_first_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule
